// File: rtl/lighting_pkg.sv
// -----------------------------------------------------------------------------
// lighting_pkg
// Shared types and constants for the lighting controllers.
//   light_state_t : 2-bit lamp/mode FSM state encoding
//   TIMER_W       : width of the auto-shutdown inactivity timer
//   lamp_on()     : lamp enable decoded from a state
//   is_manual()   : mode indicator decoded from a state
// -----------------------------------------------------------------------------
package lighting_pkg;

    localparam int TIMER_W = 16;

    typedef enum logic [1:0] {
        AUTO_OFF   = 2'b00,
        AUTO_ON    = 2'b01,
        MANUAL_OFF = 2'b10,
        MANUAL_ON  = 2'b11
    } light_state_t;

    function automatic logic lamp_on(input light_state_t s);
        return (s == AUTO_ON) || (s == MANUAL_ON);
    endfunction

    function automatic logic is_manual(input light_state_t s);
        return (s == MANUAL_OFF) || (s == MANUAL_ON);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous level input.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears both flops to 0
//   d_i : asynchronous input level
//   q_o : synchronized level, two clk edges behind d_i
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture chain; meta_q may go metastable and is never used elsewhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/light_mode_ctrl.sv
// -----------------------------------------------------------------------------
// light_mode_ctrl
// Lamp and mode controller fed by classified button pulses and a presence
// sensor. Auto mode follows presence with an inactivity shutdown timer;
// manual mode toggles the lamp on short presses. Long press swaps modes.
//   AUTO_SHUTDOWN_T : absent-presence cycles before auto shutdown (1..65535)
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   A        : long-press pulse (one cycle), toggles mode
//   B        : short-press pulse (one cycle), toggles lamp in manual mode
//   presence : raw presence level, asynchronous
//   lamp     : lamp enable, 1 = on
//   mode     : 0 = automatic, 1 = manual
// -----------------------------------------------------------------------------
module light_mode_ctrl
    import lighting_pkg::*;
#(
    parameter int unsigned AUTO_SHUTDOWN_T = 30000
) (
    input  logic clk,
    input  logic rst,
    input  logic A,
    input  logic B,
    input  logic presence,
    output logic lamp,
    output logic mode
);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(AUTO_SHUTDOWN_T - 1);

    logic                presence_s;
    light_state_t        state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic                lamp_q;
    logic                mode_q;

    sync_2ff u_presence_sync (
        .clk (clk),
        .rst (rst),
        .d_i (presence),
        .q_o (presence_s)
    );

    // Next-state and timer logic; A overrides B, B overrides presence_s.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (A) begin
            // Mode swap; any B in this cycle is dropped.
            case (state_q)
                AUTO_OFF, AUTO_ON:     state_d = MANUAL_OFF;
                MANUAL_OFF, MANUAL_ON: state_d = AUTO_OFF;
                default:               state_d = AUTO_OFF;
            endcase
            timer_d = {TIMER_W{1'b0}};
        end else begin
            case (state_q)
                AUTO_OFF: begin
                    if (presence_s) begin
                        state_d = AUTO_ON;
                        timer_d = {TIMER_W{1'b0}};
                    end else begin
                        state_d = AUTO_OFF;
                        timer_d = timer_q;
                    end
                end
                AUTO_ON: begin
                    if (presence_s) begin
                        // Retrigger: presence restarts the inactivity window.
                        timer_d = {TIMER_W{1'b0}};
                    end else if (timer_q == TIMER_LAST) begin
                        state_d = AUTO_OFF;
                        timer_d = {TIMER_W{1'b0}};
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
                MANUAL_OFF: begin
                    if (B) begin
                        state_d = MANUAL_ON;
                    end else begin
                        state_d = MANUAL_OFF;
                    end
                    timer_d = {TIMER_W{1'b0}};
                end
                MANUAL_ON: begin
                    if (B) begin
                        state_d = MANUAL_OFF;
                    end else begin
                        state_d = MANUAL_ON;
                    end
                    timer_d = {TIMER_W{1'b0}};
                end
                default: begin
                    state_d = AUTO_OFF;
                    timer_d = {TIMER_W{1'b0}};
                end
            endcase
        end
    end

    // State, timer and output registers; outputs are decoded from the next
    // state so they change on the same edge as the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= AUTO_OFF;
            timer_q <= {TIMER_W{1'b0}};
            lamp_q  <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            lamp_q  <= lamp_on(state_d);
            mode_q  <= is_manual(state_d);
        end
    end

    assign lamp = lamp_q;
    assign mode = mode_q;

endmodule

// File: tb/tb_light_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_light_mode_ctrl
// Directed self-checking bench. Main instance uses AUTO_SHUTDOWN_T = 10; a
// second instance with AUTO_SHUTDOWN_T = 1 shares all inputs to cover the
// single-cycle shutdown boundary.
// -----------------------------------------------------------------------------
module tb_light_mode_ctrl;

    logic clk;
    logic clk_en;
    logic rst;
    logic A;
    logic B;
    logic presence;
    logic lamp;
    logic mode;
    logic lamp1;
    logic mode1;

    int checks;
    int errors;

    light_mode_ctrl #(.AUTO_SHUTDOWN_T(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .presence (presence),
        .lamp     (lamp),
        .mode     (mode)
    );

    light_mode_ctrl #(.AUTO_SHUTDOWN_T(1)) dut_t1 (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .presence (presence),
        .lamp     (lamp1),
        .mode     (mode1)
    );

    // Gated clock so reset can be exercised with no edges at all.
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Async reset with clock stopped, then presence-to-lamp latency.
    task automatic test_reset();
        clk_en = 1'b1;
        rst = 1'b1;
        A = 1'b0; B = 1'b0; presence = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        // Get into MANUAL_ON so reset has something to clear.
        A = 1'b1; tick(); A = 1'b0;
        B = 1'b1; tick(); B = 1'b0;
        checks++;
        if (lamp !== 1'b1 || mode !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_manual_on: lamp=%b mode=%b expected lamp=1 mode=1", lamp, mode);
        end
        clk_en = 1'b0;   // clk sits high, no further edges
        #3;
        rst = 1'b1;
        #2;
        checks++;
        if (lamp !== 1'b0 || mode !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_no_clock: lamp=%b mode=%b expected lamp=0 mode=0", lamp, mode);
        end
        clk_en = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        // presence high for one cycle, captured at edge 0.
        for (int e = 0; e <= 2; e++) begin
            presence = (e == 0);
            tick();
            presence = 1'b0;
            checks++;
            if (lamp !== (e == 2)) begin
                errors++;
                $display("FAIL auto_on_latency edge%0d: lamp=%b expected %b", e, lamp, (e == 2));
            end
        end
        // Let the lamp time out so the next test starts from AUTO_OFF.
        for (int i = 0; i < 12; i++) tick();
        checks++;
        if (lamp !== 1'b0) begin
            errors++;
            $display("FAIL auto_on_settle: lamp=%b expected 0", lamp);
        end
    endtask

    // T=10 lamp on after edges 2..11; T=1 lamp on only after edge 2.
    task automatic test_auto_shutdown();
        for (int e = 0; e <= 14; e++) begin
            presence = (e == 0);
            tick();
            presence = 1'b0;
            checks++;
            if (lamp !== (e >= 2 && e <= 11) || lamp1 !== (e == 2) || mode !== 1'b0) begin
                errors++;
                $display("FAIL auto_shutdown edge%0d: lamp=%b lamp_t1=%b mode=%b expected lamp=%b lamp_t1=%b mode=0",
                         e, lamp, lamp1, mode, (e >= 2 && e <= 11), (e == 2));
            end
        end
    endtask

    // Second pulse captured at edge 9 reaches the FSM at edge 11 with timer=8.
    task automatic test_retrigger();
        for (int e = 0; e <= 24; e++) begin
            presence = (e == 0 || e == 9);
            tick();
            presence = 1'b0;
            checks++;
            if (lamp !== (e >= 2 && e <= 20)) begin
                errors++;
                $display("FAIL retrigger edge%0d: lamp=%b expected %b", e, lamp, (e >= 2 && e <= 20));
            end
        end
    endtask

    // Manual mode: B toggles lamp, presence ignored.
    task automatic test_manual();
        logic [2:0] exp_lamp;
        exp_lamp = 3'b101;
        A = 1'b1; tick(); A = 1'b0;
        checks++;
        if (mode !== 1'b1 || lamp !== 1'b0 || mode1 !== 1'b1) begin
            errors++;
            $display("FAIL manual_enter: mode=%b lamp=%b mode_t1=%b expected mode=1 lamp=0 mode_t1=1", mode, lamp, mode1);
        end
        for (int i = 0; i < 3; i++) begin
            B = 1'b1; presence = ~presence; tick(); B = 1'b0;
            checks++;
            if (lamp !== exp_lamp[2-i] || mode !== 1'b1) begin
                errors++;
                $display("FAIL manual_b%0d: lamp=%b mode=%b expected lamp=%b mode=1", i, lamp, mode, exp_lamp[2-i]);
            end
            for (int j = 0; j < 3; j++) begin
                presence = ~presence; tick();
                checks++;
                if (lamp !== exp_lamp[2-i]) begin
                    errors++;
                    $display("FAIL manual_hold%0d_%0d: lamp=%b expected %b", i, j, lamp, exp_lamp[2-i]);
                end
            end
        end
        presence = 1'b0;
    endtask

    // Same-cycle priorities and back-to-back B; entered in MANUAL_ON.
    task automatic test_simultaneous();
        A = 1'b1; B = 1'b1; tick(); A = 1'b0; B = 1'b0;
        checks++;
        if (mode !== 1'b0 || lamp !== 1'b0) begin
            errors++;
            $display("FAIL a_and_b_manual_on: mode=%b lamp=%b expected mode=0 lamp=0", mode, lamp);
        end
        // Flush the synchronizer and any stale presence.
        presence = 1'b0;
        tick(); tick(); tick();
        B = 1'b1; tick(); B = 1'b0;
        checks++;
        if (mode !== 1'b0 || lamp !== 1'b0) begin
            errors++;
            $display("FAIL b_in_auto_off: mode=%b lamp=%b expected mode=0 lamp=0", mode, lamp);
        end
        presence = 1'b1; tick(); presence = 1'b0; tick(); tick();
        checks++;
        if (lamp !== 1'b1 || mode !== 1'b0) begin
            errors++;
            $display("FAIL auto_on_again: lamp=%b mode=%b expected lamp=1 mode=0", lamp, mode);
        end
        A = 1'b1; tick(); A = 1'b0;
        checks++;
        if (mode !== 1'b1 || lamp !== 1'b0) begin
            errors++;
            $display("FAIL a_in_auto_on: mode=%b lamp=%b expected mode=1 lamp=0", mode, lamp);
        end
        B = 1'b1; tick();
        checks++;
        if (lamp !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back_b1: lamp=%b expected 1", lamp);
        end
        tick(); B = 1'b0;
        checks++;
        if (lamp !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_b2: lamp=%b expected 0", lamp);
        end
        A = 1'b1; tick(); A = 1'b0;
        checks++;
        if (mode !== 1'b0 || lamp !== 1'b0) begin
            errors++;
            $display("FAIL back_to_auto: mode=%b lamp=%b expected mode=0 lamp=0", mode, lamp);
        end
    endtask

    // Async reset while the auto timer is at 5.
    task automatic test_reset_mid_count();
        for (int e = 0; e <= 7; e++) begin
            presence = (e == 0);
            tick();
            presence = 1'b0;
        end
        checks++;
        if (lamp !== 1'b1) begin
            errors++;
            $display("FAIL mid_count_lamp_on: lamp=%b expected 1", lamp);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (lamp !== 1'b0 || mode !== 1'b0) begin
            errors++;
            $display("FAIL mid_count_async_reset: lamp=%b mode=%b expected lamp=0 mode=0", lamp, mode);
        end
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (lamp !== 1'b0) begin
                errors++;
                $display("FAIL after_reset_off%0d: lamp=%b expected 0", i, lamp);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk_en = 1'b0;
        rst = 1'b1;
        A = 1'b0;
        B = 1'b0;
        presence = 1'b0;
        test_reset();
        test_auto_shutdown();
        test_retrigger();
        test_manual();
        test_simultaneous();
        test_reset_mid_count();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/light_mode_ctrl.md
# light_mode_ctrl

Lamp and mode controller that consumes the classified push-button pulses from the button-press stage: `A` for a long press and `B` for a short press. It also takes a presence-sensor input. It runs the lamp in automatic mode (presence-driven with an inactivity shutdown timer) or manual mode (short press toggles the lamp). A long press switches between the two modes. The block sits directly downstream of the button classifier and drives the lamp enable and the mode indicator.

## Interface
- `AUTO_SHUTDOWN_T`, 30000, consecutive clock cycles of absent (synchronized) presence before the lamp turns off in auto mode; legal range 1..65535
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `A`  in  1  long-press pulse, one cycle wide, synchronous to `clk`
- `B`  in  1  short-press pulse, one cycle wide, synchronous to `clk`
- `presence`  in  1  raw presence-sensor level, asynchronous to `clk`
- `lamp`  out  1  lamp enable, 1 = on
- `mode`  out  1  0 = automatic, 1 = manual

## Operation
- `presence` passes through a 2-flop synchronizer; its output is `presence_s`. `A` and `B` are used directly, since they are already synchronous.
- The FSM has 4 states; reset state is `AUTO_OFF`. A 16-bit `timer` resets to 0.
- Priority: `A` beats `B`, and `B` beats `presence_s`, in the same cycle.
- Any state with `A`=1 toggles mode:
  - `AUTO_OFF` or `AUTO_ON` go to `MANUAL_OFF`.
  - `MANUAL_OFF` or `MANUAL_ON` go to `AUTO_OFF`.
  - `timer` <= 0.
  - A `B` in that same cycle is discarded.
- `AUTO_OFF`:
  - `presence_s`=1 goes to `AUTO_ON`, with `timer` <= 0.
  - `B` is ignored.
- `AUTO_ON`:
  - `presence_s`=1 sets `timer` <= 0 (retrigger).
  - `presence_s`=0 with `timer`==`AUTO_SHUTDOWN_T`-1 goes to `AUTO_OFF`, with `timer` <= 0.
  - Otherwise `presence_s`=0 increments `timer`.
  - `B` is ignored.
- `MANUAL_OFF`: `B` goes to `MANUAL_ON`.
- `MANUAL_ON`: `B` goes to `MANUAL_OFF`.
- In both manual states, `presence_s` is ignored and `timer` is held at 0.
- `timer` never exceeds `AUTO_SHUTDOWN_T`-1, so no wrap is possible.
- Outputs are decoded from the state register only, so they are glitch-free:
  - `lamp` = state in {`AUTO_ON`, `MANUAL_ON`}
  - `mode` = state in {`MANUAL_OFF`, `MANUAL_ON`}
- Unreachable state encodings recover to `AUTO_OFF` on the next edge.

## Timing
- Reset values: `lamp`=0, `mode`=0, state `AUTO_OFF`, `timer`=0, synchronizer flops 0. `rst` forces these immediately, with no clock edge needed, including in the middle of a timer count.
- `A`/`B` latency: the pulse is sampled at edge n; `lamp` and `mode` hold their new value after edge n.
- `presence` latency: the level is captured at edge n into the first synchronizer flop. It is acted on at edge n+2, so `lamp` is high after edge n+2.
- Auto shutdown: `lamp` falls after the edge that samples the `AUTO_SHUTDOWN_T`-th consecutive `presence_s`=0.
- With `AUTO_SHUTDOWN_T`=1, `lamp` falls on the first `presence_s`=0 sample.
- Back-to-back `B` pulses on consecutive cycles each toggle the lamp.

## Structure
- Shared package `lighting_pkg` holds:
  - `light_state_t`, a 2-bit enum: `AUTO_OFF`, `AUTO_ON`, `MANUAL_OFF`, `MANUAL_ON`
  - `TIMER_W` = 16
- Sub-module `sync_2ff` (1-bit, `clk`/`rst` async reset to 0) synchronizes `presence`; it is reusable for other sensor inputs.
- The FSM, timer and output decode stay in `light_mode_ctrl`.

## Test plan
- Reset and auto-on latency: assert `rst` mid-simulation with no clock running; `lamp`=0 and `mode`=0 immediately. Release `rst`, then hold `presence`=1 for 1 cycle starting at edge 0; `lamp` rises after edge 2.
- Auto shutdown, `AUTO_SHUTDOWN_T`=10: after a 1-cycle `presence` pulse, `lamp` is high for exactly 10 cycles, from after edge 2 to after edge 12.
- Retrigger, `AUTO_SHUTDOWN_T`=10: a second `presence` pulse arriving when `timer`=8 keeps `lamp`=1 continuously. `lamp` falls 10 cycles after the second pulse's `presence_s` sample.
- Manual mode: an `A` pulse gives `mode`=1 and `lamp`=0 after the same edge. `B`, `B`, `B` pulses give `lamp` = 1, 0, 1. `presence` toggling meanwhile has no effect.
- Simultaneous events:
  - In `MANUAL_ON`, `A`=`B`=1 in the same cycle gives `AUTO_OFF` (`mode`=0, `lamp`=0).
  - In `AUTO_ON`, `A`=1 gives `mode`=1, `lamp`=0.
  - In `AUTO_OFF`, `B` alone causes no change.
- Reset mid-count: in `AUTO_ON` with `timer`=5, assert `rst` asynchronously; `lamp` drops to 0 before the next edge. After release, with `presence`=0, the lamp stays off.
